// File: rtl/card_dealer_arb.sv
// Card dealer arbiter: grants one requester at a time a random card from a 52-card shoe.
// Define RR_ARB_EN for round-robin arbitration; fixed priority dealer > player > split otherwise.
module card_dealer_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_dealer,
    input  logic       req_player,
    input  logic       req_split,
    input  logic       shuffle,
    output logic [2:0] gnt,
    output logic       card_valid,
    output logic [3:0] card_rank,
    output logic [5:0] card_value,
    output logic [5:0] cards_left,
    output logic       shoe_empty,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAW    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [5:0]  FULL_SHOE = 6'd52;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  cards_left_q, cards_left_d;
    logic [2:0]  grant_q, grant_d;
    logic [3:0]  rank_q, rank_d;
    logic [5:0]  value_q, value_d;
    logic [2:0]  req_vec;
    logic [2:0]  winner;
    logic [3:0]  candidate;
    logic        candidate_ok;

    function automatic logic [5:0] rank_to_value(input logic [3:0] rank);
        logic [5:0] value;
        if (rank == 4'd1) begin
            value = 6'd11;
        end else if (rank >= 4'd11) begin
            value = 6'd10;
        end else begin
            value = {2'b00, rank};
        end
        return value;
    endfunction

    assign req_vec      = {req_dealer, req_player, req_split};
    assign candidate    = lfsr_q[3:0];
    assign candidate_ok = (candidate != 4'd0) && (candidate <= 4'd13);

`ifdef RR_ARB_EN
    // Pointer is one-hot in grant bit order; the ring visits player -> split -> dealer.
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [2:0] rr_c1, rr_c2;

    function automatic logic [2:0] rr_next(input logic [2:0] who);
        logic [2:0] nxt;
        case (who)
            3'b010:  nxt = 3'b001;
            3'b001:  nxt = 3'b100;
            3'b100:  nxt = 3'b010;
            default: nxt = 3'b010;
        endcase
        return nxt;
    endfunction

    always_comb begin
        rr_c1  = rr_next(rr_ptr_q);
        rr_c2  = rr_next(rr_c1);
        winner = 3'b000;
        if ((req_vec & rr_ptr_q) != 3'b000) begin
            winner = rr_ptr_q;
        end else if ((req_vec & rr_c1) != 3'b000) begin
            winner = rr_c1;
        end else if ((req_vec & rr_c2) != 3'b000) begin
            winner = rr_c2;
        end
    end
`else
    always_comb begin
        winner = 3'b000;
        if (req_dealer) begin
            winner = 3'b100;
        end else if (req_player) begin
            winner = 3'b010;
        end else if (req_split) begin
            winner = 3'b001;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rank_d       = rank_q;
        value_d      = value_q;
        cards_left_d = cards_left_q;
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
`ifdef RR_ARB_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if ((winner != 3'b000) && (cards_left_q != 6'd0)) begin
                    grant_d = winner;
                    state_d = DRAW;
`ifdef RR_ARB_EN
                    rr_ptr_d = rr_next(winner);
`endif
                end
            end
            DRAW: begin
                if (candidate_ok) begin
                    rank_d  = candidate;
                    value_d = rank_to_value(candidate);
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                cards_left_d = cards_left_q - 6'd1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A shuffle overrides a same-cycle delivery decrement.
        if (shuffle) begin
            cards_left_d = FULL_SHOE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_SEED;
            cards_left_q <= FULL_SHOE;
            grant_q      <= 3'b000;
            rank_q       <= 4'd0;
            value_q      <= 6'd0;
`ifdef RR_ARB_EN
            rr_ptr_q     <= 3'b010;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            cards_left_q <= cards_left_d;
            grant_q      <= grant_d;
            rank_q       <= rank_d;
            value_q      <= value_d;
`ifdef RR_ARB_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign card_valid = (state_q == DELIVER);
    assign gnt        = (state_q == DELIVER) ? grant_q : 3'b000;
    assign busy       = (state_q != IDLE);
    assign card_rank  = rank_q;
    assign card_value = value_q;
    assign cards_left = cards_left_q;
    assign shoe_empty = (cards_left_q == 6'd0);

endmodule

// File: doc/card_dealer_arb.md
CARD_DEALER_ARB -- requirements
Module: card_dealer_arb

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge system clock.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_dealer, req_player, req_split  in  1 each  card requests, held high until the grant.
REQ-004 SHALL have ports: shuffle  in  1  restores a full 52-card shoe.
REQ-005 SHALL have ports: gnt  out  3  one-hot grant {dealer, player, split}, valid only with card_valid.
REQ-006 SHALL have ports: card_valid  out  1  one-cycle card delivery strobe.
REQ-007 SHALL have ports: card_rank  out  4  rank 1..13 (1=ace, 11..13=J/Q/K).
REQ-008 SHALL have ports: card_value  out  6  blackjack value, 2..11.
REQ-009 SHALL have ports: cards_left  out  6  cards remaining, 0..52.
REQ-010 SHALL have ports: shoe_empty  out  1  high when cards_left==0.
REQ-011 SHALL have ports: busy  out  1  high in DRAW or DELIVER.

Function
REQ-012 SHALL implement an FSM with states IDLE, DRAW and DELIVER.
REQ-013 In IDLE with at least one request and cards_left>0, SHALL latch the winning requester and go to DRAW next cycle.
REQ-014 SHALL keep a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11) that advances every cycle, seed 16'hACE1.
REQ-015 In DRAW, SHALL take LFSR[3:0] as the candidate rank; 1..13 SHALL be accepted and move the FSM to DELIVER; 0, 14 or 15 SHALL keep it in DRAW.
REQ-016 In DELIVER, SHALL assert card_valid and the latched one-hot gnt for exactly one cycle, decrement cards_left by 1, then return to IDLE.
REQ-017 card_rank/card_value SHALL be registered at DRAW exit and held until the next delivery.
REQ-018 Value mapping SHALL be: rank 1 -> 11; ranks 2..10 -> rank; ranks 11..13 -> 10.
REQ-019 Minimum request-to-card_valid latency SHALL be 2 cycles; minimum spacing between deliveries SHALL be 3 cycles.
REQ-020 A requester dropping req during DRAW SHALL still receive the delivery (the card is consumed).
REQ-021 Requests SHALL be ignored while cards_left==0; no gnt, busy stays low.
REQ-022 shuffle in any state SHALL set cards_left=52 next cycle; if it coincides with a DELIVER decrement, the result SHALL be 52.
REQ-023 shuffle SHALL NOT abort a DRAW or DELIVER in progress.
REQ-024 A requester still holding req after its card_valid SHALL be treated as a new request in the following IDLE.

Reset
REQ-025 On reset: state=IDLE, LFSR=16'hACE1, cards_left=52, gnt=0, card_valid=0, card_rank=0, card_value=0, busy=0, shoe_empty=0.
REQ-026 Reset during DRAW or DELIVER SHALL abort with no card_valid and no decrement; reset SHALL take priority over shuffle and requests.

Configuration
REQ-027 Macro RR_ARB_EN SHALL select the arbitration scheme.
REQ-028 Without RR_ARB_EN: fixed priority dealer > player > split.
REQ-029 With RR_ARB_EN: round-robin over player -> split -> dealer -> player; after reset the pointer SHALL be at player and SHALL move to the requester after the one granted.

Verification
REQ-030 Reset, then idle for 10 cycles -> cards_left=52, gnt=0, card_valid=0, shoe_empty=0, busy=0.
REQ-031 52 back-to-back req_player draws -> 52 card_valid pulses each with gnt=3'b010, every card_rank in 1..13, final cards_left=0, shoe_empty=1; a 53rd request held 20 cycles -> no gnt.
REQ-032 req_dealer and req_player raised in the same cycle and held -> without RR_ARB_EN, dealer served first, then player; with RR_ARB_EN after reset, player first, then dealer.
REQ-033 Force ranks 1, 7 and 12 through the mapping -> card_value 11, 7 and 10 respectively.
REQ-034 Assert reset in the DRAW cycle after a grant -> no card_valid, cards_left=52, state IDLE; shuffle in the same cycle as DELIVER at cards_left=5 -> cards_left=52.
